// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard sequencer: PC write, IF/ID hold/flush and ID/EX bubble control.
// Optional PIPE_HAZARD_CTRL_PERF_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CW             = 4,
    parameter int unsigned BRANCH_BUBBLES = 1,
    parameter int unsigned PERF_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_use_hz,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              ext_stall_req,
    input  logic [CW-1:0]     ext_stall_cycles,
    input  logic              halt_i,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [2:0]        state_o,
    output logic [PERF_W-1:0] stall_cycles_o,
    output logic [PERF_W-1:0] flush_cycles_o
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_RUN   = 3'd1,
        S_STALL = 3'd2,
        S_FLUSH = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [CW-1:0] BR_RELOAD    = CW'(BRANCH_BUBBLES - 1);
    localparam bit            MULTI_BUBBLE = (BRANCH_BUBBLES > 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [CW-1:0] stall_len;
    logic          branch_go;

    // A zero-length request still freezes for the current cycle.
    assign stall_len = (ext_stall_cycles == '0) ? '0 : ext_stall_cycles - CW'(1);
    assign branch_go = branch_taken &&
                       (state == S_RUN || state == S_STALL || state == S_FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_nx    = state;
        cnt_nx      = cnt;

        if (branch_go) begin
            // Taken branch wins in RUN, aborts STALL and restarts the FLUSH window.
            pc_en       = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (MULTI_BUBBLE) begin
                state_nx = S_FLUSH;
                cnt_nx   = BR_RELOAD;
            end else begin
                state_nx = S_RUN;
                cnt_nx   = '0;
            end
        end else begin
            case (state)
                S_INIT: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_nx    = S_RUN;
                    cnt_nx      = '0;
                end
                S_RUN: begin
                    if (jump) begin
                        pc_en       = 1'b1;
                        if_id_flush = 1'b1;
                    end else if (halt_i) begin
                        state_nx = S_HALT;
                    end else if (ext_stall_req) begin
                        cnt_nx   = stall_len;
                        state_nx = (stall_len == '0) ? S_RUN : S_STALL;
                    end else if (load_use_hz) begin
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                    end
                end
                S_STALL: begin
                    if (cnt <= CW'(1)) begin
                        cnt_nx   = '0;
                        state_nx = S_RUN;
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                S_FLUSH: begin
                    pc_en       = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (cnt <= CW'(1)) begin
                        cnt_nx   = '0;
                        state_nx = S_RUN;
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                S_HALT: begin
                    if (!halt_i) state_nx = S_RUN;
                end
                default: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_nx    = S_INIT;
                    cnt_nx      = '0;
                end
            endcase
        end
    end

    assign state_o = state;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && stall_q != '1)      stall_q <= stall_q + PERF_W'(1);
            if (if_id_flush && flush_q != '1) flush_q <= flush_q + PERF_W'(1);
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_cycles_o = flush_q;
`else
    assign stall_cycles_o = '0;
    assign flush_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (BRANCH_BUBBLES=2): directed cycles push
// expected {pc_en,if_id_en,if_id_flush,id_ex_flush,state}; a negedge monitor checks.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW     = 4;
    localparam int unsigned PERF_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_use_hz = 1'b0;
    logic              branch_taken = 1'b0;
    logic              jump = 1'b0;
    logic              ext_stall_req = 1'b0;
    logic [CW-1:0]     ext_stall_cycles = '0;
    logic              halt_i = 1'b0;
    logic              pc_en, if_id_en, if_id_flush, id_ex_flush;
    logic [2:0]        state_o;
    logic [PERF_W-1:0] stall_cycles_o, flush_cycles_o;

    pipe_hazard_ctrl #(
        .CW             (CW),
        .BRANCH_BUBBLES (2),
        .PERF_W         (PERF_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_use_hz      (load_use_hz),
        .branch_taken     (branch_taken),
        .jump             (jump),
        .ext_stall_req    (ext_stall_req),
        .ext_stall_cycles (ext_stall_cycles),
        .halt_i           (halt_i),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .state_o          (state_o),
        .stall_cycles_o   (stall_cycles_o),
        .flush_cycles_o   (flush_cycles_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [6:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        n_tests = 0;
    int        n_fail  = 0;

    // Expected vectors {pc_en, if_id_en, if_id_flush, id_ex_flush, state[2:0]}
    localparam logic [6:0] E_INIT  = 7'b0011_000;
    localparam logic [6:0] E_RUN   = 7'b1100_001;
    localparam logic [6:0] E_LU    = 7'b0001_001;
    localparam logic [6:0] E_FRZ   = 7'b0000_001;
    localparam logic [6:0] E_STALL = 7'b0000_010;
    localparam logic [6:0] E_BR    = 7'b1011_001;
    localparam logic [6:0] E_BRST  = 7'b1011_010;
    localparam logic [6:0] E_FLUSH = 7'b1011_011;
    localparam logic [6:0] E_JMP   = 7'b1010_001;
    localparam logic [6:0] E_HALT  = 7'b0000_100;

    task automatic step(input string nm, input logic r, input logic lu, input logic br,
                        input logic jp, input logic es, input logic [CW-1:0] esc,
                        input logic ht, input logic [6:0] exp);
        sb_entry_t e;
        @(posedge clk);
        #1;
        rst_n            = r;
        load_use_hz      = lu;
        branch_taken     = br;
        jump             = jp;
        ext_stall_req    = es;
        ext_stall_cycles = esc;
        halt_i           = ht;
        e.name = nm;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        logic [6:0] act;
        sb_entry_t  e;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {pc_en, if_id_en, if_id_flush, id_ex_flush, state_o};
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, act, e.exp);
            end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
            if (!rst_n) begin
                n_tests++;
                if (stall_cycles_o !== '0 || flush_cycles_o !== '0) begin
                    n_fail++;
                    $display("FAIL %s_perf: got %0d/%0d required 0/0", e.name,
                             stall_cycles_o, flush_cycles_o);
                end
            end
`else
            n_tests++;
            if (stall_cycles_o !== '0 || flush_cycles_o !== '0) begin
                n_fail++;
                $display("FAIL %s_perf_tied: got %0d/%0d required 0/0", e.name,
                         stall_cycles_o, flush_cycles_o);
            end
`endif
        end
    end

    initial begin
        //    name           rst lu br jp es esc   ht expected
        step("reset",        0, 0, 0, 0, 0, 4'd0, 0, E_INIT);
        step("init_cycle",   1, 0, 0, 0, 0, 4'd0, 0, E_INIT);
        step("run",          1, 0, 0, 0, 0, 4'd0, 0, E_RUN);
        step("load_use",     1, 1, 0, 0, 0, 4'd0, 0, E_LU);
        step("after_lu",     1, 0, 0, 0, 0, 4'd0, 0, E_RUN);
        step("stall3_c1",    1, 0, 0, 0, 1, 4'd3, 0, E_FRZ);
        step("stall3_c2",    1, 0, 0, 0, 0, 4'd0, 0, E_STALL);
        step("stall3_c3",    1, 0, 0, 0, 0, 4'd0, 0, E_STALL);
        step("stall3_end",   1, 0, 0, 0, 0, 4'd0, 0, E_RUN);
        step("stall0_c1",    1, 0, 0, 0, 1, 4'd0, 0, E_FRZ);
        step("stall0_end",   1, 0, 0, 0, 0, 4'd0, 0, E_RUN);
        step("br_c1",        1, 0, 1, 0, 0, 4'd0, 0, E_BR);
        step("br_c2",        1, 0, 0, 0, 0, 4'd0, 0, E_FLUSH);
        step("br_end",       1, 0, 0, 0, 0, 4'd0, 0, E_RUN);
        step("br2_c1",       1, 0, 1, 0, 0, 4'd0, 0, E_BR);
        step("br2_reload",   1, 0, 1, 0, 0, 4'd0, 0, E_FLUSH);
        step("br2_c3",       1, 0, 0, 0, 0, 4'd0, 0, E_FLUSH);
        step("br2_end",      1, 0, 0, 0, 0, 4'd0, 0, E_RUN);
        step("prio_br",      1, 1, 1, 1, 0, 4'd0, 0, E_BR);
        step("prio_br_c2",   1, 0, 0, 0, 0, 4'd0, 0, E_FLUSH);
        step("jump",         1, 0, 0, 1, 0, 4'd0, 0, E_JMP);
        step("after_jump",   1, 0, 0, 0, 0, 4'd0, 0, E_RUN);
        step("stall4_c1",    1, 0, 0, 0, 1, 4'd4, 0, E_FRZ);
        step("stall4_c2",    1, 0, 0, 0, 0, 4'd0, 0, E_STALL);
        step("stall_abort",  1, 1, 1, 1, 1, 4'd7, 0, E_BRST);
        step("abort_flush",  1, 0, 0, 0, 0, 4'd0, 0, E_FLUSH);
        step("abort_end",    1, 0, 0, 0, 0, 4'd0, 0, E_RUN);
        step("halt_enter",   1, 0, 0, 0, 0, 4'd0, 1, E_FRZ);
        step("halt_br_ign",  1, 0, 1, 0, 0, 4'd0, 1, E_HALT);
        step("halt_fall",    1, 0, 0, 0, 0, 4'd0, 0, E_HALT);
        step("halt_end",     1, 0, 0, 0, 0, 4'd0, 0, E_RUN);
        step("stall6_c1",    1, 0, 0, 0, 1, 4'd6, 0, E_FRZ);
        step("rst_in_stall", 0, 0, 0, 0, 0, 4'd0, 0, E_INIT);
        step("rst_release",  1, 0, 0, 0, 0, 4'd0, 0, E_INIT);
        step("no_residual",  1, 0, 0, 0, 0, 4'd0, 0, E_RUN);
        step("halt_vs_st",   1, 0, 0, 0, 1, 4'd3, 1, E_FRZ);
        step("halt_vs_st2",  1, 0, 0, 0, 0, 4'd0, 0, E_HALT);
        step("final_run",    1, 0, 0, 0, 0, 4'd0, 0, E_RUN);
        step("idle_tail",    1, 0, 0, 0, 0, 4'd0, 0, E_RUN);

        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
